pwm_gen_mc: RTL



---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_deadtime.sv | 55 +++++
 rtl/pwm_gen_mc.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} mode_t;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  localparam int PWM_WIDTH = 11;
  localparam int PWM_NCH   = 3;
  localparam int PWM_DT_W  = 6;
  localparam int PWM_BLANK = 255;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel complementary gate driver with dead-time insertion.
// Any change of raw_q first drops both gates, then after `deadtime` cycles
// turns on the side that matches the settled raw_q level.
module pwm_deadtime #(
  parameter int DT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            raw_q,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  localparam logic [DT_W-1:0] ONE = DT_W'(1);

  logic            raw_d;
  logic [DT_W-1:0] dcnt;

  // Edge detect on raw_q, dead-time countdown, gate update on expiry.
  // A toggle while counting restarts the countdown with both gates low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_d <= 1'b0;
      dcnt  <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (clr) begin
      raw_d <= 1'b0;
      dcnt  <= '0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else if (raw_q != raw_d) begin
      raw_d <= raw_q;
      if (deadtime == '0) begin
        hi   <= raw_q;
        lo   <= ~raw_q;
        dcnt <= '0;
      end else begin
        hi   <= 1'b0;
        lo   <= 1'b0;
        dcnt <= deadtime;
      end
    end else if (dcnt > ONE) begin
      dcnt <= dcnt - ONE;
    end else begin
      // Count expiring (1) or idle (0): gates follow the settled level.
      dcnt <= '0;
      hi   <= raw_q;
      lo   <= ~raw_q;
    end
  end

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM: shared edge/center counter, double-buffered duty,
// per-channel compare + dead time, period synch and overcurrent blanking.
module pwm_gen_mc
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH,
  parameter int NCH   = PWM_NCH,
  parameter int DT_W  = PWM_DT_W,
  parameter int BLANK = PWM_BLANK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 center_mode,
  input  logic [NCH*WIDTH-1:0] duty,
  input  logic                 duty_vld,
  input  logic [DT_W-1:0]      deadtime,
  output logic [WIDTH-1:0]     cnt,
  output logic                 cnt_all_zeros,
  output logic [NCH-1:0]       PWM_hi,
  output logic [NCH-1:0]       PWM_lo,
  output logic                 PWM_synch,
  output logic                 OVR_I_blank_n
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam int               BW      = $clog2(BLANK + 1);
  localparam logic [BW-1:0]    BLANK_V = BW'(BLANK);
  localparam logic [BW-1:0]    BONE    = BW'(1);

  dir_t                        dir;
  mode_t                       mode;
  logic                        pend;
  logic                        boundary;
  logic                        clr;
  logic [NCH-1:0][WIDTH-1:0]   duty_in;
  logic [NCH-1:0][WIDTH-1:0]   shadow;
  logic [NCH-1:0][WIDTH-1:0]   active;
  logic [NCH-1:0][WIDTH-1:0]   duty_sel;
  logic [NCH-1:0]              raw_q;
  logic [NCH-1:0]              hi_prev;
  logic [BW-1:0]               bcnt;

  assign duty_in       = duty;
  assign boundary      = en && (cnt == '0);
  assign clr           = ~en;
  assign cnt_all_zeros = (cnt == '0);
  assign OVR_I_blank_n = (bcnt == '0);

  // Duty the compare uses this cycle: at a boundary the newly applied value,
  // so a strobe landing on cnt==0 shapes the period it starts.
  always_comb begin
    duty_sel = active;
    if (boundary) begin
      if (duty_vld)  duty_sel = duty_in;
      else if (pend) duty_sel = shadow;
    end
  end

  // Counter and direction; cnt==0 always steps up to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (!en) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (cnt == '0) begin
      cnt <= ONE;
      dir <= DIR_UP;
    end else if (mode == PWM_EDGE) begin
      cnt <= cnt + ONE;
    end else if (dir == DIR_UP) begin
      if (cnt == MAX) begin
        cnt <= MAX - ONE;
        dir <= DIR_DOWN;
      end else begin
        cnt <= cnt + ONE;
      end
    end else begin
      cnt <= cnt - ONE;
    end
  end

  // Shadow/active duty double buffer and mode latch at the period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      pend   <= 1'b0;
      mode   <= PWM_EDGE;
    end else begin
      if (duty_vld) shadow <= duty_in;
      active <= duty_sel;
      if (boundary) begin
        mode <= center_mode ? PWM_CENTER : PWM_EDGE;
        pend <= 1'b0;
      end else if (duty_vld) begin
        pend <= 1'b1;
      end
    end
  end

  // Registered per-channel compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_q <= '0;
    else for (int i = 0; i < NCH; i++) raw_q[i] <= en && (cnt < duty_sel[i]);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .raw_q    (raw_q[i]),
      .deadtime (deadtime),
      .hi       (PWM_hi[i]),
      .lo       (PWM_lo[i])
    );
  end

  // Period synch pulse, high the cycle after each boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PWM_synch <= 1'b0;
    else        PWM_synch <= boundary;
  end

  // Blanking window: reload on any high-side rising edge, count down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_prev <= '0;
      bcnt    <= '0;
    end else begin
      hi_prev <= PWM_hi;
      if (!en)                       bcnt <= '0;
      else if (|(PWM_hi & ~hi_prev)) bcnt <= BLANK_V;
      else if (bcnt != '0)           bcnt <= bcnt - BONE;
    end
  end

endmodule
